// File: rtl/cacheline_rr_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cacheline_rr_arbiter_if
// Brief    : Requester/memory bundle for the shared cacheline memory port.
//            The slave modport is the arbiter's view. The master modport is
//            the environment's view: the requesters plus the memory.
// Revision : 1.0 - initial release
// ============================================================================
interface cacheline_rr_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  // Requester side
  logic [2:0]          req_read;
  logic [2:0]          req_write;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*LINE_W-1:0] req_wdata;
  logic [LINE_W-1:0]   req_rdata;
  logic [2:0]          req_resp;
  // Memory side
  logic                mem_read;
  logic                mem_write;
  logic [ADDR_W-1:0]   mem_addr;
  logic [LINE_W-1:0]   mem_wdata;
  logic [LINE_W-1:0]   mem_rdata;
  logic                mem_resp;
  // Status
  logic [1:0]          grant_id;
  logic                busy;

  modport slave (
    input  req_read, req_write, req_addr, req_wdata, mem_rdata, mem_resp,
    output req_rdata, req_resp, mem_read, mem_write, mem_addr, mem_wdata,
           grant_id, busy
  );

  modport master (
    output req_read, req_write, req_addr, req_wdata, mem_rdata, mem_resp,
    input  req_rdata, req_resp, mem_read, mem_write, mem_addr, mem_wdata,
           grant_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/cacheline_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cacheline_rr_arbiter
// Brief    : Three-way round-robin arbiter that shares one cacheline memory
//            port between the I-cache (0), the D-cache (1) and the prefetcher
//            (2). It runs one latched transaction at a time and routes the
//            completion only to the owner.
// Revision : 1.0 - initial release
// ============================================================================
module cacheline_rr_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  cacheline_rr_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RECOVER = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        r_last;       // last owner; search starts just after it
  logic [1:0]        r_owner;      // current owner, doubles as grant_id
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;

  logic [2:0]        w_active;
  logic              w_any;
  logic [1:0]        w_winner;
  logic              w_win_write;
  logic [ADDR_W-1:0] w_win_addr;
  logic [LINE_W-1:0] w_win_wdata;
  logic              w_done;

  assign w_active = bus.req_read | bus.req_write;
  assign w_any    = |w_active;
  assign w_done   = (r_state == S_BUSY) && bus.mem_resp;

  // Round-robin pick: first active requester after the last owner, with wrap
  always_comb begin
    w_winner = 2'd0;
    case (r_last)
      2'd0: begin
        if      (w_active[1]) w_winner = 2'd1;
        else if (w_active[2]) w_winner = 2'd2;
        else                  w_winner = 2'd0;
      end
      2'd1: begin
        if      (w_active[2]) w_winner = 2'd2;
        else if (w_active[0]) w_winner = 2'd0;
        else                  w_winner = 2'd1;
      end
      default: begin
        if      (w_active[0]) w_winner = 2'd0;
        else if (w_active[1]) w_winner = 2'd1;
        else                  w_winner = 2'd2;
      end
    endcase
  end

  // Select the winner's command, address and write line
  always_comb begin
    w_win_write = bus.req_write[0];
    w_win_addr  = bus.req_addr[0 +: ADDR_W];
    w_win_wdata = bus.req_wdata[0 +: LINE_W];
    case (w_winner)
      2'd1: begin
        w_win_write = bus.req_write[1];
        w_win_addr  = bus.req_addr[ADDR_W +: ADDR_W];
        w_win_wdata = bus.req_wdata[LINE_W +: LINE_W];
      end
      2'd2: begin
        w_win_write = bus.req_write[2];
        w_win_addr  = bus.req_addr[2*ADDR_W +: ADDR_W];
        w_win_wdata = bus.req_wdata[2*LINE_W +: LINE_W];
      end
      default: begin
        w_win_write = bus.req_write[0];
        w_win_addr  = bus.req_addr[0 +: ADDR_W];
        w_win_wdata = bus.req_wdata[0 +: LINE_W];
      end
    endcase
  end

  // Transaction FSM: latch the winner in IDLE, hold it until mem_resp, then idle one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 2'd2;
      r_owner     <= 2'd0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner     <= w_winner;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
            // A write takes priority and a simultaneous read is dropped
            r_mem_write <= w_win_write;
            r_mem_read  <= ~w_win_write;
            r_state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (bus.mem_resp) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_last      <= r_owner;
            r_state     <= S_RECOVER;
          end
        end
        S_RECOVER: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.grant_id  = r_owner;
  assign bus.busy      = (r_state == S_BUSY) || (r_state == S_RECOVER);

  // The completion reaches only the owner, in the same cycle as mem_resp
  assign bus.req_resp  = w_done ? (3'b001 << r_owner) : 3'b000;
  assign bus.req_rdata = w_done ? bus.mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cacheline_rr_arbiter
// Brief    : Scoreboard bench for cacheline_rr_arbiter. It applies directed
//            requests and uses a latency-programmable memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cacheline_rr_arbiter;
  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cacheline_rr_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  cacheline_rr_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]        resp;
    logic [LINE_W-1:0] rdata;
    bit                chk_data;
  } exp_t;

  exp_t              sb_q[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                mem_lat  = 1000;
  int                mem_cnt  = 0;
  bit                spur_req = 1'b0;
  logic [LINE_W-1:0] rd_val   = '0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] resp, input logic [LINE_W-1:0] rdata,
                          input bit chk_data);
    exp_t e;
    e.resp = resp;
    e.rdata = rdata;
    e.chk_data = chk_data;
    sb_q.push_back(e);
  endtask

  // Drive point: just after the active edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sample point: opposite edge
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_resp(input int max, input string name);
    int k = 0;
    do begin
      cyc();
      smp();
      k++;
    end while (bus.req_resp == 3'b000 && k < max);
    if (bus.req_resp == 3'b000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no req_resp within %0d cycles", name, max);
    end
  endtask

  task automatic wait_cmd(input int max, input string name);
    int k = 0;
    do begin
      cyc();
      smp();
      k++;
    end while (!(bus.mem_read || bus.mem_write) && k < max);
    if (!(bus.mem_read || bus.mem_write)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no memory command within %0d cycles", name, max);
    end
  endtask

  // Drop all requests in RECOVER, then confirm the dead cycle and the return to IDLE
  task automatic finish_txn(input string name);
    cyc();
    bus.req_read = 3'b000;
    bus.req_write = 3'b000;
    smp();
    chk({name, "_recover_busy"}, bus.busy, 1'b1);
    chk({name, "_recover_nocmd"}, bus.mem_read | bus.mem_write, 1'b0);
    cyc();
    smp();
    chk({name, "_idle_busy"}, bus.busy, 1'b0);
  endtask

  // Memory model: responds mem_lat cycles after the command first appears
  initial begin
    bus.mem_resp = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      cyc();
      bus.mem_resp = 1'b0;
      bus.mem_rdata = rd_val;
      if (rst || !(bus.mem_read || bus.mem_write)) begin
        mem_cnt = 0;
      end else begin
        mem_cnt++;
        if (mem_cnt == mem_lat + 1) bus.mem_resp = 1'b1;
      end
      if (spur_req) begin
        bus.mem_resp = 1'b1;
        spur_req = 1'b0;
      end
    end
  end

  // Monitor: every completion pops the scoreboard; otherwise req_rdata must be zero
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.req_resp != 3'b000) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got req_resp %0b, expected none", bus.req_resp);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_resp", bus.req_resp, e.resp);
          if (e.chk_data) chk("sb_rdata", bus.req_rdata, e.rdata);
        end
      end else begin
        chk("rdata_idle", bus.req_rdata, '0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [1:0] RR_SEQ [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

  initial begin
    bus.req_read = 3'b000;
    bus.req_write = 3'b000;
    bus.req_addr = '0;
    bus.req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    smp();
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_req_resp", bus.req_resp, '0);
    chk("rst_req_rdata", bus.req_rdata, '0);
    chk("rst_grant_id", bus.grant_id, '0);
    chk("rst_busy", bus.busy, 1'b0);

    // Test 1: single I-fetch, exact latency
    cyc();
    rd_val = {8{32'hDEAD_BEEF}};
    mem_lat = 4;
    bus.req_read = 3'b001;
    bus.req_addr[0 +: ADDR_W] = 32'h0000_0060;
    push_exp(3'b001, {8{32'hDEAD_BEEF}}, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      cyc();
      if (c == 6) bus.req_read = 3'b000;
      smp();
      if (c == 1) begin
        chk("t1_mem_read", bus.mem_read, 1'b1);
        chk("t1_mem_addr", bus.mem_addr, 32'h60);
        chk("t1_grant", bus.grant_id, 2'd0);
      end
      if (c == 4) chk("t1_no_early_resp", bus.req_resp, 3'b000);
      if (c == 5) chk("t1_resp_c5", bus.req_resp, 3'b001);
      if (c == 6) begin
        chk("t1_resp_c6", bus.req_resp, 3'b000);
        chk("t1_busy_c6", bus.busy, 1'b1);
        chk("t1_cmd_c6", bus.mem_read, 1'b0);
      end
      if (c == 7) chk("t1_busy_c7", bus.busy, 1'b0);
    end

    // Test 2: D-cache writeback
    cyc();
    mem_lat = 3;
    rd_val = {8{32'h1234_5678}};
    bus.req_write = 3'b010;
    bus.req_addr[ADDR_W +: ADDR_W] = 32'h0000_0100;
    bus.req_wdata[LINE_W +: LINE_W] = {32{8'hA5}};
    push_exp(3'b010, '0, 1'b0);
    cyc();
    smp();
    chk("t2_mem_write", bus.mem_write, 1'b1);
    chk("t2_mem_read", bus.mem_read, 1'b0);
    chk("t2_mem_addr", bus.mem_addr, 32'h100);
    chk("t2_mem_wdata", bus.mem_wdata, {32{8'hA5}});
    chk("t2_grant", bus.grant_id, 2'd1);
    wait_resp(20, "t2_wait_resp");
    finish_txn("t2");

    // Test 3: round-robin with all three held active from reset
    cyc();
    rst = 1'b1;
    bus.req_read = 3'b111;
    bus.req_addr = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    mem_lat = 3;
    cyc();
    rst = 1'b0;
    smp();
    for (int t = 0; t < 5; t++) begin
      logic [1:0] g;
      logic [LINE_W-1:0] d;
      g = RR_SEQ[t];
      d = {8{32'hC0DE_0000 + 32'(t)}};
      rd_val = d;
      push_exp(3'b001 << g, d, 1'b1);
      wait_cmd(20, "t3_wait_cmd");
      chk("t3_grant", bus.grant_id, g);
      chk("t3_mem_addr", bus.mem_addr, 32'h0000_1000 * (32'(g) + 32'd1));
      if (t == 4) bus.req_read = 3'b000;
      wait_resp(20, "t3_wait_resp");
      cyc();
      smp();
      chk("t3_gap_recover", bus.mem_read | bus.mem_write, 1'b0);
      chk("t3_recover_busy", bus.busy, 1'b1);
      cyc();
      smp();
      chk("t3_gap_idle", bus.mem_read | bus.mem_write, 1'b0);
      chk("t3_idle_busy", bus.busy, 1'b0);
    end

    // Test 4: latched command survives input changes and request drop
    rd_val = {8{32'h0BAD_F00D}};
    mem_lat = 4;
    cyc();
    bus.req_read = 3'b001;
    bus.req_addr[0 +: ADDR_W] = 32'h0000_0060;
    push_exp(3'b001, {8{32'h0BAD_F00D}}, 1'b1);
    cyc();
    smp();
    chk("t4_mem_read", bus.mem_read, 1'b1);
    chk("t4_grant", bus.grant_id, 2'd0);
    for (int c = 2; c <= 4; c++) begin
      cyc();
      if (c == 2) begin
        bus.req_addr[0 +: ADDR_W] = 32'hFFFF_FFE0;
        bus.req_read = 3'b000;
      end
      smp();
      chk("t4_hold_read", bus.mem_read, 1'b1);
      chk("t4_hold_addr", bus.mem_addr, 32'h60);
    end
    wait_resp(10, "t4_wait_resp");
    finish_txn("t4");

    // Test 5: spurious mem_resp in IDLE, then read+write on requester 1
    rd_val = {8{32'hBAD0_BAD0}};
    spur_req = 1'b1;
    cyc();
    smp();
    chk("t5_spur_resp", bus.req_resp, 3'b000);
    chk("t5_spur_busy", bus.busy, 1'b0);
    cyc();
    smp();
    chk("t5_spur_state", bus.busy, 1'b0);
    mem_lat = 3;
    cyc();
    bus.req_read = 3'b010;
    bus.req_write = 3'b010;
    bus.req_addr[ADDR_W +: ADDR_W] = 32'h0000_0200;
    bus.req_wdata[LINE_W +: LINE_W] = {32{8'h3C}};
    push_exp(3'b010, '0, 1'b0);
    cyc();
    smp();
    chk("t5_mem_write", bus.mem_write, 1'b1);
    chk("t5_mem_read", bus.mem_read, 1'b0);
    chk("t5_mem_addr", bus.mem_addr, 32'h200);
    chk("t5_mem_wdata", bus.mem_wdata, {32{8'h3C}});
    chk("t5_grant", bus.grant_id, 2'd1);
    wait_resp(20, "t5_wait_resp");
    finish_txn("t5");

    // Test 6: reset in the third BUSY cycle aborts the transaction
    mem_lat = 1000;
    rd_val = {8{32'h6666_0001}};
    cyc();
    bus.req_read = 3'b010;
    bus.req_addr[ADDR_W +: ADDR_W] = 32'h0000_0300;
    cyc();
    smp();
    chk("t6_grant", bus.grant_id, 2'd1);
    chk("t6_mem_read", bus.mem_read, 1'b1);
    cyc();
    cyc();
    rst = 1'b1;
    bus.req_read = 3'b110;
    bus.req_addr[2*ADDR_W +: ADDR_W] = 32'h0000_0400;
    cyc();
    rst = 1'b0;
    smp();
    chk("t6_rst_mem_read", bus.mem_read, 1'b0);
    chk("t6_rst_busy", bus.busy, 1'b0);
    chk("t6_rst_grant", bus.grant_id, 2'd0);
    chk("t6_rst_resp", bus.req_resp, 3'b000);
    mem_lat = 2;
    push_exp(3'b010, {8{32'h6666_0001}}, 1'b1);
    cyc();
    smp();
    chk("t6_regrant", bus.grant_id, 2'd1);
    chk("t6_regrant_read", bus.mem_read, 1'b1);
    chk("t6_regrant_addr", bus.mem_addr, 32'h300);
    wait_resp(10, "t6_wait_resp");
    finish_txn("t6");

    repeat (3) cyc();
    smp();
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
